// File: rtl/tt_mux_slot_ctrl.sv
// tt_mux_slot_ctrl: owns NUM_SLOTS project wrappers on one shared packed input
// bus. Exactly one slot is enabled at a time. Switching is sequenced as drain
// (old slot held in reset) -> reset (new slot held in reset) -> run.
// The selected slot's packed output is registered back to the host.
// Optional build macro: TT_MUX_SLOT_CTRL_OE_MASK_EN. When it is defined, the
// uio_out field returned to the host is masked by the slot's uio_oe.
module tt_mux_slot_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int IW           = 18,
  parameter int OW           = 24,
  parameter int PW           = 8,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int SEL_W        = $clog2(NUM_SLOTS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel_slot,
  output logic                    sel_ready,
  input  logic [IW-1:0]           host_iw,
  output logic [OW-1:0]           host_ow,
  output logic [IW-1:0]           slot_iw,
  output logic [NUM_SLOTS-1:0]    slot_ena,
  input  logic [NUM_SLOTS*OW-1:0] slot_ow,
  output logic                    active,
  output logic [SEL_W-1:0]        cur_slot
);

  localparam int MAXC = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [SEL_W-1:0] NONE = SEL_W'(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, DRAIN, RESET, RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] pend_slot;
  logic [IW-1:1]    iw_q;
  logic [OW-1:0]    ow_sel;
  logic             xfer, sel_ok, pend_ok, cnt_exp;

  assign xfer    = sel_valid && sel_ready;
  assign sel_ok  = sel_slot < NONE;
  assign pend_ok = pend_slot < NONE;
  assign cnt_exp = cnt == CW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && sel_ok) state_nxt = RESET;
      RUN:     if (xfer) state_nxt = DRAIN;
      DRAIN:   if (cnt_exp) state_nxt = pend_ok ? RESET : IDLE;
      RESET:   if (cnt_exp) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot ownership and phase counter; the counter runs down to 1 so each
  // phase lasts exactly its parameter's number of cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cur_slot  <= NONE;
      pend_slot <= NONE;
    end else begin
      case (state)
        IDLE: if (xfer && sel_ok) begin
          cur_slot <= sel_slot;
          cnt      <= CW'(RST_CYCLES);
        end
        RUN: if (xfer) begin
          pend_slot <= sel_slot;
          cnt       <= CW'(DRAIN_CYCLES);
        end
        DRAIN: begin
          if (cnt_exp) begin
            if (pend_ok) begin
              cur_slot <= pend_slot;
              cnt      <= CW'(RST_CYCLES);
            end else begin
              cur_slot <= NONE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESET: if (!cnt_exp) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // FSM outputs: handshake, run flag, one-hot ena, shared bus with gated rst_n
  always_comb begin
    sel_ready = (state == IDLE) || (state == RUN);
    active    = (state == RUN);
    slot_ena  = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      slot_ena[k] = (state != IDLE) && (cur_slot == SEL_W'(k));
    slot_iw    = {iw_q[IW-1:2], (state == RUN) ? iw_q[1] : 1'b0, host_iw[0]};
  end

  // Host input register; bit0 (project clock) bypasses it
  always_ff @(posedge clk) begin
    if (rst) iw_q <= '0;
    else     iw_q <= host_iw[IW-1:1];
  end

  // Select the owned slot's output bus
  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < NUM_SLOTS; k++)
      if (cur_slot == SEL_W'(k)) ow_sel = slot_ow[k*OW +: OW];
`ifdef TT_MUX_SLOT_CTRL_OE_MASK_EN
    ow_sel[2*PW-1:PW] = ow_sel[2*PW-1:PW] & ow_sel[3*PW-1:2*PW];
`endif
  end

  // Registered output to host; zero whenever no slot is running
  always_ff @(posedge clk) begin
    if (rst)                host_ow <= '0;
    else if (state == RUN)  host_ow <= ow_sel;
    else                    host_ow <= '0;
  end

endmodule

// File: tb/tb_tt_mux_slot_ctrl.sv
// Self-checking bench for tt_mux_slot_ctrl with default parameters.
module tb_tt_mux_slot_ctrl;
  localparam int NUM_SLOTS = 4;
  localparam int IW = 18;
  localparam int OW = 24;
  localparam int PW = 8;
  localparam int SEL_W = $clog2(NUM_SLOTS) + 1;

  logic clk = 0;
  logic rst = 1;
  logic sel_valid = 0;
  logic [SEL_W-1:0] sel_slot = '0;
  logic sel_ready;
  logic [IW-1:0] host_iw = '0;
  logic [OW-1:0] host_ow;
  logic [IW-1:0] slot_iw;
  logic [NUM_SLOTS-1:0] slot_ena;
  logic [NUM_SLOTS-1:0][OW-1:0] sow = '0;
  logic active;
  logic [SEL_W-1:0] cur_slot;

  int errors = 0;
  int checks = 0;

  logic [OW-1:0] exp_ow_q[$];
  logic [IW-1:0] exp_iw_q[$];

  tt_mux_slot_ctrl dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_slot(sel_slot),
    .sel_ready(sel_ready), .host_iw(host_iw), .host_ow(host_ow),
    .slot_iw(slot_iw), .slot_ena(slot_ena), .slot_ow(sow),
    .active(active), .cur_slot(cur_slot)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [OW-1:0] model_ow(input logic [OW-1:0] v);
    logic [OW-1:0] r;
    r = v;
`ifdef TT_MUX_SLOT_CTRL_OE_MASK_EN
    r[2*PW-1:PW] = v[2*PW-1:PW] & v[3*PW-1:2*PW];
`endif
    return r;
  endfunction

  // One transfer cycle, then back to idle handshake
  task automatic request(input logic [SEL_W-1:0] s);
    sel_slot = s; sel_valid = 1;
    step();
    sel_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1; step(3); rst = 0;
    checks++; if (slot_ena !== 4'b0000) begin errors++; $display("FAIL reset_ena got=%b exp=0000", slot_ena); end
    checks++; if (host_ow !== 24'h0) begin errors++; $display("FAIL reset_host_ow got=%h exp=0", host_ow); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (cur_slot !== 3'd4) begin errors++; $display("FAIL reset_cur_slot got=%0d exp=4", cur_slot); end
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", sel_ready); end
    checks++; if (slot_iw[IW-1:1] !== '0) begin errors++; $display("FAIL reset_slot_iw got=%h exp=0", slot_iw); end
  endtask

  task automatic test_select_idle;
    host_iw = 18'h3_0002;  // rst_n high from host
    request(3'd2);         // now at T+1
    for (int c = 1; c <= 4; c++) begin
      checks++; if (slot_ena !== 4'b0100) begin errors++; $display("FAIL sel_ena T+%0d got=%b exp=0100", c, slot_ena); end
      checks++; if (slot_iw[1] !== 1'b0) begin errors++; $display("FAIL sel_rstn T+%0d got=%b exp=0", c, slot_iw[1]); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL sel_active T+%0d got=%b exp=0", c, active); end
      step();
    end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL sel_active T+5 got=%b exp=1", active); end
    checks++; if (slot_iw[1] !== 1'b1) begin errors++; $display("FAIL sel_rstn T+5 got=%b exp=1", slot_iw[1]); end
    checks++; if (cur_slot !== 3'd2) begin errors++; $display("FAIL sel_cur got=%0d exp=2", cur_slot); end
    host_iw[1] = 0; step();
    checks++; if (slot_iw[1] !== 1'b0) begin errors++; $display("FAIL sel_rstn_track got=%b exp=0", slot_iw[1]); end
    host_iw[1] = 1; step();
  endtask

  // Scoreboard: expected output/bus values queued at drive time, checked next cycle
  task automatic test_output_path;
    logic [OW-1:0] eo;
    logic [IW-1:0] ei;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NUM_SLOTS; k++) sow[k] = 24'hFFFFFF;
      sow[2] = (i == 0) ? 24'hA5C33C : OW'($urandom);
      host_iw = IW'($urandom);
      host_iw[1] = 1;
      exp_ow_q.push_back(model_ow(sow[2]));
      exp_iw_q.push_back(host_iw);
      step();
      checks++; if (slot_iw[0] !== host_iw[0]) begin errors++; $display("FAIL clk_pass got=%b exp=%b", slot_iw[0], host_iw[0]); end
      eo = exp_ow_q.pop_front();
      ei = exp_iw_q.pop_front();
      checks++; if (host_ow !== eo) begin errors++; $display("FAIL out_path[%0d] got=%h exp=%h", i, host_ow, eo); end
      checks++; if (slot_iw[IW-1:1] !== ei[IW-1:1]) begin errors++; $display("FAIL iw_reg[%0d] got=%h exp=%h", i, slot_iw[IW-1:1], ei[IW-1:1]); end
    end
  endtask

  task automatic test_switch;
    logic [NUM_SLOTS-1:0] e;
    request(3'd1);  // T+1
    for (int c = 1; c <= 6; c++) begin
      e = (c <= 2) ? 4'b0100 : 4'b0010;
      checks++; if (sel_ready !== 1'b0) begin errors++; $display("FAIL sw_ready T+%0d got=%b exp=0", c, sel_ready); end
      checks++; if (slot_ena !== e) begin errors++; $display("FAIL sw_ena T+%0d got=%b exp=%b", c, slot_ena, e); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL sw_active T+%0d got=%b exp=0", c, active); end
      if (c == 4) begin sel_valid = 1; sel_slot = 3'd3; end
      else sel_valid = 0;
      step();
    end
    sel_valid = 0;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL sw_active T+7 got=%b exp=1", active); end
    checks++; if (slot_ena !== 4'b0010) begin errors++; $display("FAIL sw_ena T+7 got=%b exp=0010", slot_ena); end
    checks++; if (cur_slot !== 3'd1) begin errors++; $display("FAIL sw_cur got=%0d exp=1", cur_slot); end
  endtask

  task automatic test_deselect;
    sow[1] = 24'h123456;
    request(3'd7);  // T+1, DRAIN
    for (int c = 1; c <= 2; c++) begin
      checks++; if (slot_ena !== 4'b0010) begin errors++; $display("FAIL desel_ena T+%0d got=%b exp=0010", c, slot_ena); end
      step();
    end
    checks++; if (slot_ena !== 4'b0000) begin errors++; $display("FAIL desel_ena_idle got=%b exp=0000", slot_ena); end
    checks++; if (cur_slot !== 3'd4) begin errors++; $display("FAIL desel_cur got=%0d exp=4", cur_slot); end
    checks++; if (host_ow !== 24'h0) begin errors++; $display("FAIL desel_host_ow got=%h exp=0", host_ow); end
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL desel_ready got=%b exp=1", sel_ready); end
    request(3'd5);  // invalid slot from IDLE: stays idle
    checks++; if (slot_ena !== 4'b0000 || sel_ready !== 1'b1) begin errors++; $display("FAIL idle_invalid ena=%b ready=%b exp=0000/1", slot_ena, sel_ready); end
  endtask

  task automatic test_oe_mask;
    logic [PW-1:0] e;
    request(3'd0);
    step(4);
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL oe_run got=%b exp=1", active); end
    sow[0] = {8'h0F, 8'hFF, 8'h5A};
    step();
`ifdef TT_MUX_SLOT_CTRL_OE_MASK_EN
    e = 8'h0F;
`else
    e = 8'hFF;
`endif
    checks++; if (host_ow[2*PW-1:PW] !== e) begin errors++; $display("FAIL oe_mask got=%h exp=%h", host_ow[2*PW-1:PW], e); end
    checks++; if (host_ow[PW-1:0] !== 8'h5A || host_ow[3*PW-1:2*PW] !== 8'h0F) begin errors++; $display("FAIL oe_fields got=%h exp=0F??5A", host_ow); end
  endtask

  task automatic test_reset_mid;
    rst = 1; step(); rst = 0; step();
    request(3'd3);
    step();         // mid-RESET
    checks++; if (slot_ena !== 4'b1000) begin errors++; $display("FAIL mid_ena got=%b exp=1000", slot_ena); end
    rst = 1; step(); rst = 0;
    checks++; if (slot_ena !== 4'b0000) begin errors++; $display("FAIL mid_rst_ena got=%b exp=0000", slot_ena); end
    checks++; if (cur_slot !== 3'd4) begin errors++; $display("FAIL mid_rst_cur got=%0d exp=4", cur_slot); end
    checks++; if (active !== 1'b0 || host_ow !== 24'h0) begin errors++; $display("FAIL mid_rst_out active=%b host_ow=%h exp=0/0", active, host_ow); end
    checks++; if (slot_iw[IW-1:1] !== '0) begin errors++; $display("FAIL mid_rst_iw got=%h exp=0", slot_iw); end
    checks++; if (sel_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", sel_ready); end
    step(6);        // counter must not resume the aborted reset
    checks++; if (slot_ena !== 4'b0000 || active !== 1'b0) begin errors++; $display("FAIL mid_rst_hold ena=%b active=%b exp=0000/0", slot_ena, active); end
  endtask

  initial begin
    test_reset();
    test_select_idle();
    test_output_path();
    test_switch();
    test_deselect();
    test_oe_mask();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
